// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into aligned word accesses on a
// word-wide data memory, with read-modify-write for sub-word stores and fault detection.
module lsu_lane (
  input  logic       be,
  input  logic [7:0] base,
  input  logic [7:0] wr,
  output logic [7:0] out
);
  assign out = be ? wr : base;
endmodule

module load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h9600_0000,
  parameter int          WIN_BITS  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;
  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  state_t   state;
  lsu_req_t req_q;
  logic     rdy_q, rsp_q, we_q;

  // Handshake outputs are forced low whenever reset is asserted, even mid-cycle.
  assign req_ready = rdy_q & reset;
  assign rsp_valid = rsp_q & reset;
  assign mem_WE    = we_q  & reset;
  assign mem_A     = (state == LOAD || state == READ || state == WRITE) ?
                     {req_q.addr[31:2], 2'b00} : 32'h0;

  logic out_win, bad_f3, misal, fault_in;
  always_comb begin
    out_win  = req_addr[31:WIN_BITS] != BASE_ADDR[31:WIN_BITS];
    bad_f3   = req_we ? (req_funct3 > 3'd2)
                      : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misal    = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    fault_in = out_win | bad_f3 | misal;
  end

  logic [NUM_LANES-1:0][7:0] rd_b, wrep, mrg;
  logic [NUM_LANES-1:0]      be;
  logic [7:0]                ld_b;
  logic [15:0]               ld_h;
  logic [31:0]               ld_data;

  assign rd_b = mem_RD;

  always_comb begin
    ld_b = rd_b[req_q.addr[1:0]];
    ld_h = req_q.addr[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (req_q.funct3)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'h0, ld_b};
      3'b101:  ld_data = {16'h0, ld_h};
      default: ld_data = mem_RD;
    endcase
  end

  // Store data is replicated across lanes so each lane only needs a byte enable.
  always_comb begin
    be   = '1;
    wrep = req_q.wdata;
    case (req_q.funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << req_q.addr[1:0];
        wrep = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be   = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane u_lane (.be(be[i]), .base(rd_b[i]), .wr(wrep[i]), .out(mrg[i]));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_q     <= '0;
      rdy_q     <= 1'b1;
      rsp_q     <= 1'b0;
      we_q      <= 1'b0;
      mem_WD    <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q <= '{funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          rdy_q <= 1'b0;
          if (fault_in) begin
            state     <= RESP;
            rsp_q     <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= 32'h0;
          end else if (!req_we) begin
            state <= LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state  <= WRITE;
            we_q   <= 1'b1;
            mem_WD <= req_wdata;
          end else begin
            state <= READ;
          end
        end
        LOAD: begin
          state     <= RESP;
          rsp_q     <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= ld_data;
        end
        READ: begin
          state  <= WRITE;
          we_q   <= 1'b1;
          mem_WD <= mrg;
        end
        WRITE: begin
          state     <= RESP;
          we_q      <= 1'b0;
          mem_WD    <= 32'h0;
          rsp_q     <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        RESP: begin
          state <= IDLE;
          rsp_q <= 1'b0;
          rdy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
